// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and defaults for seq_restoring_divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W = 4;
  localparam logic DBZ_QBIT = 1'b1;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration
module div_step #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_r,
  input  logic         i_bit,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_r,
  output logic         o_q
);
  logic [W:0] w_t;
  assign w_t = {i_r, i_bit};
  assign o_q = w_t >= {1'b0, i_d};
  // r < divisor always holds, so the restored remainder fits back in W bits
  assign o_r = o_q ? W'(w_t - {1'b0, i_d}) : w_t[W-1:0];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides
// Optional: define DIV_EARLY_TERM_EN to finish in one edge when dividend < divisor.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W = DEF_DIVISOR_W,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [DIVIDEND_W-1:0] r_dsh, r_quot;
  logic [DIVISOR_W-1:0] r_dvs, r_rem, w_rem_nx;
  logic r_dbz, w_acc, w_zero, w_early, w_qbit;
  assign in_ready = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign w_acc = in_valid && in_ready;
  assign w_zero = divisor == '0;
`ifdef DIV_EARLY_TERM_EN
  assign w_early = !w_zero && (dividend < DIVIDEND_W'(divisor));
`else
  assign w_early = 1'b0;
`endif
  assign quotient = r_quot;
  assign remainder = r_rem;
  assign div_by_zero = r_dbz;
  div_step #(.W(DIVISOR_W)) u_step (
    .i_r  (r_rem),
    .i_bit(r_dsh[DIVIDEND_W-1]),
    .i_d  (r_dvs),
    .o_r  (w_rem_nx),
    .o_q  (w_qbit)
  );
  always_comb begin
    w_next = r_state;
    if (w_acc) w_next = (w_zero || w_early) ? DONE : CALC;
    if (r_state == CALC && r_cnt == '0) w_next = DONE;
    if (out_valid && out_ready) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_dsh <= '0;
      r_dvs <= '0;
      r_quot <= '0;
      r_rem <= '0;
      r_dbz <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_dsh <= dividend;
        r_dvs <= divisor;
        r_cnt <= CNT_W'(DIVIDEND_W - 1);
        r_dbz <= w_zero;
        r_quot <= w_zero ? {DIVIDEND_W{DBZ_QBIT}} : '0;
        r_rem <= (w_zero || w_early) ? dividend[DIVISOR_W-1:0] : '0;
      end else if (r_state == CALC) begin
        r_dsh <= r_dsh << 1;
        r_quot <= {r_quot[DIVIDEND_W-2:0], w_qbit};
        r_rem <= w_rem_nx;
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: table vectors, corner sequences and full operand sweep with a result scoreboard
module tb_seq_restoring_divider;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] dividend = '0, quotient;
  logic [3:0] divisor = '0, remainder;
  logic in_ready, out_valid, div_by_zero;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic dz;
  } exp_t;
  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic dz;
    int hold;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[10];
  always #5 clk = ~clk;
  seq_restoring_divider dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input logic [7:0] q,
                        input logic [3:0] r, input logic dz, input int hold);
    exp_t e;
    int lat, el;
    e.q = q;
    e.r = r;
    e.dz = dz;
    sb.push_back(e);
    el = (b == 0) ? 1 : 9;
`ifdef DIV_EARLY_TERM_EN
    if (b != 0 && a < {4'd0, b}) el = 1;
`endif
    @(negedge clk);
    dividend = a;
    divisor = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", lat, el);
    e = sb.pop_front();
    chk("quotient", quotient, e.q);
    chk("remainder", remainder, e.r);
    chk("div_by_zero", div_by_zero, e.dz);
    if (hold > 0) begin
      in_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #1 chk("hold_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_quotient", quotient, e.q);
        chk("hold_remainder", remainder, e.r);
      end
      in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b1;
    chk("in_ready_before_pop", in_ready, 0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("out_valid_after_pop", out_valid, 0);
    chk("in_ready_after_pop", in_ready, 1);
  endtask
  initial begin
    tbl[0] = '{8'd200, 4'd13, 8'd15, 4'd5, 1'b0, 0};
    tbl[1] = '{8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 0};
    tbl[2] = '{8'd143, 4'd15, 8'd9, 4'd8, 1'b0, 0};
    tbl[3] = '{8'd100, 4'd0, 8'hFF, 4'd4, 1'b1, 0};
    tbl[4] = '{8'd77, 4'd6, 8'd12, 4'd5, 1'b0, 20};
    tbl[5] = '{8'd3, 4'd9, 8'd0, 4'd3, 1'b0, 0};
    tbl[6] = '{8'd0, 4'd5, 8'd0, 4'd0, 1'b0, 0};
    tbl[7] = '{8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 0};
    tbl[8] = '{8'd15, 4'd15, 8'd1, 4'd0, 1'b0, 0};
    tbl[9] = '{8'd14, 4'd15, 8'd0, 4'd14, 1'b0, 3};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    for (int i = 0; i < 10; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].hold);
    // abort an operation in its fourth CALC cycle
    @(negedge clk);
    dividend = 8'd200;
    divisor = 4'd13;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_in_ready", in_ready, 1);
    run_op(8'd50, 4'd7, 8'd7, 4'd1, 1'b0, 0);
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++)
        if (b == 0) run_op(8'(a), 4'd0, 8'hFF, 4'(a), 1'b1, 0);
        else run_op(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
